// File: rtl/mac_stream_engine_pkg.sv
// mac_stream_engine_pkg: shared FSM state type and default parameters for the MAC stream engine
package mac_stream_engine_pkg;
  localparam int ELEM_W_DEF = 8;
  localparam int LANES_DEF  = 4;
  localparam int ACC_W_DEF  = 32;
  localparam int K_MAX_DEF  = 64;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    OUTPUT = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/mac_stream_engine_lane.sv
// mac_lane: one signed multiply-accumulate lane with synchronous clear and enable
module mac_lane #(
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [ELEM_W-1:0] a,
  input  logic signed [ELEM_W-1:0] b,
  output logic        [ACC_W-1:0]  acc
);
  logic signed [2*ELEM_W-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else acc <= clr ? '0 : en ? acc + ACC_W'(prod) : acc;
endmodule

// File: rtl/mac_stream_engine.sv
// mac_stream_engine: streams K joint A/B beats through LANES signed MACs, then emits one C beat per lane
module mac_stream_engine
  import mac_stream_engine_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_MAX  = K_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*ELEM_W-1:0] s_axis_a_tdata,
  input  logic                    s_axis_a_tvalid,
  output logic                    s_axis_a_tready,
  input  logic                    s_axis_a_tlast,
  input  logic [LANES*ELEM_W-1:0] s_axis_b_tdata,
  input  logic                    s_axis_b_tvalid,
  output logic                    s_axis_b_tready,
  input  logic                    s_axis_b_tlast,
  output logic [ACC_W-1:0]        m_axis_c_tdata,
  output logic                    m_axis_c_tvalid,
  input  logic                    m_axis_c_tready,
  output logic                    m_axis_c_tlast,
  input  logic [15:0]             cfg_k,
  input  logic                    start,
  input  logic                    irq_en,
  input  logic                    sw_clear_done,
  output logic                    busy,
  output logic                    done,
  output logic                    done_pulse,
  output logic                    err,
  output logic                    irq
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  state_t           state;
  logic [15:0]      k;
  logic [15:0]      beat;
  logic [IW-1:0]    idx;
  logic [ACC_W-1:0] acc [LANES];
  logic             joint, clr, bad_k, last_beat, last_lane, c_valid, c_hs;
  assign joint     = state == LOAD && s_axis_a_tvalid && s_axis_b_tvalid;
  assign clr       = state == IDLE && start;
  assign bad_k     = cfg_k == 16'd0 || cfg_k > 16'(K_MAX);
  assign last_beat = beat == k - 16'd1;
  assign last_lane = idx == IW'(LANES - 1);
  assign c_valid   = state == OUTPUT;
  assign c_hs      = c_valid && m_axis_c_tready;
  assign s_axis_a_tready = joint;
  assign s_axis_b_tready = joint;
  assign m_axis_c_tvalid = c_valid;
  assign m_axis_c_tdata  = c_valid ? acc[idx] : '0;
  assign m_axis_c_tlast  = c_valid && last_lane;
  assign busy = state == LOAD || state == OUTPUT;
  assign irq  = done && irq_en;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.ELEM_W(ELEM_W), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (joint),
      .a     (s_axis_a_tdata[i*ELEM_W +: ELEM_W]),
      .b     (s_axis_b_tdata[i*ELEM_W +: ELEM_W]),
      .acc   (acc[i])
    );
  end
  // set events are written after the software clear so they take priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      beat       <= '0;
      idx        <= '0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (sw_clear_done) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          k          <= cfg_k;
          beat       <= '0;
          idx        <= '0;
          done       <= bad_k;
          err        <= bad_k;
          done_pulse <= bad_k;
          state      <= bad_k ? FINISH : LOAD;
        end
        LOAD: if (joint) begin
          beat <= beat + 16'd1;
          if (s_axis_a_tlast != last_beat || s_axis_b_tlast != last_beat) err <= 1'b1;
          if (last_beat) state <= OUTPUT;
        end
        OUTPUT: if (c_hs) begin
          idx <= idx + 1'b1;
          if (last_lane) begin
            state      <= FINISH;
            done       <= 1'b1;
            done_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mac_stream_engine.sv
// tb_mac_stream_engine: scoreboard bench for the MAC stream engine
module tb_mac_stream_engine;
  localparam int EW = 8;
  localparam int L  = 4;
  localparam int AW = 32;
  localparam int KM = 64;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [L*EW-1:0] s_axis_a_tdata, s_axis_b_tdata;
  logic          s_axis_a_tvalid, s_axis_a_tready, s_axis_a_tlast;
  logic          s_axis_b_tvalid, s_axis_b_tready, s_axis_b_tlast;
  logic [AW-1:0] m_axis_c_tdata;
  logic          m_axis_c_tvalid, m_axis_c_tready, m_axis_c_tlast;
  logic [15:0]   cfg_k;
  logic          start, irq_en, sw_clear_done;
  logic          busy, done, done_pulse, err, irq;
  typedef struct packed {
    logic [AW-1:0] data;
    logic          last;
  } exp_t;
  exp_t q[$];
  int n_cmp, n_bad, n_pulse, c_count, tr_mode;
  logic [L*EW-1:0] a_mem [KM];
  logic [L*EW-1:0] b_mem [KM];
  logic            a_last_mem [KM];
  logic            b_last_mem [KM];
  always #5 clk = ~clk;
  mac_stream_engine #(.ELEM_W(EW), .LANES(L), .ACC_W(AW), .K_MAX(KM)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_a_tdata  (s_axis_a_tdata),
    .s_axis_a_tvalid (s_axis_a_tvalid),
    .s_axis_a_tready (s_axis_a_tready),
    .s_axis_a_tlast  (s_axis_a_tlast),
    .s_axis_b_tdata  (s_axis_b_tdata),
    .s_axis_b_tvalid (s_axis_b_tvalid),
    .s_axis_b_tready (s_axis_b_tready),
    .s_axis_b_tlast  (s_axis_b_tlast),
    .m_axis_c_tdata  (m_axis_c_tdata),
    .m_axis_c_tvalid (m_axis_c_tvalid),
    .m_axis_c_tready (m_axis_c_tready),
    .m_axis_c_tlast  (m_axis_c_tlast),
    .cfg_k           (cfg_k),
    .start           (start),
    .irq_en          (irq_en),
    .sw_clear_done   (sw_clear_done),
    .busy            (busy),
    .done            (done),
    .done_pulse      (done_pulse),
    .err             (err),
    .irq             (irq)
  );
  // pops the scoreboard on every C handshake and checks hold-stability during stalls
  task automatic monitor();
    logic stall = 1'b0;
    logic [AW-1:0] pd = '0;
    logic pl = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (done_pulse) n_pulse++;
        if (stall) begin
          n_cmp++;
          if (m_axis_c_tvalid !== 1'b1 || m_axis_c_tdata !== pd || m_axis_c_tlast !== pl) begin
            n_bad++;
            $display("FAIL c_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     m_axis_c_tvalid, m_axis_c_tdata, m_axis_c_tlast, pd, pl);
          end
        end
        if (m_axis_c_tvalid && m_axis_c_tready) begin
          c_count++;
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL c_unexpected: data=%h last=%b, required no beat", m_axis_c_tdata, m_axis_c_tlast);
          end else begin
            e = q.pop_front();
            if (m_axis_c_tdata !== e.data || m_axis_c_tlast !== e.last) begin
              n_bad++;
              $display("FAIL c_beat: data=%h last=%b, required data=%h last=%b",
                       m_axis_c_tdata, m_axis_c_tlast, e.data, e.last);
            end
          end
        end
        stall = m_axis_c_tvalid && !m_axis_c_tready;
        pd = m_axis_c_tdata;
        pl = m_axis_c_tlast;
      end
    end
  endtask
  task automatic drive_tready();
    forever begin
      @(posedge clk);
      #1;
      if (tr_mode == 0) m_axis_c_tready = 1'b1;
      else if (tr_mode == 1) m_axis_c_tready = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic fill_basic();
    for (int j = 0; j < 4; j++) begin
      a_mem[j] = {4{8'd1}};
      b_mem[j] = {8'hFF, 8'd3, 8'd2, 8'd1};
      a_last_mem[j] = (j == 3);
      b_last_mem[j] = (j == 3);
    end
  endtask
  task automatic fill_rand(input int k);
    for (int j = 0; j < k; j++) begin
      a_mem[j] = $urandom;
      b_mem[j] = $urandom;
      a_last_mem[j] = (j == k - 1);
      b_last_mem[j] = (j == k - 1);
    end
  endtask
  task automatic start_job(input int k, input bit start_mid);
    int s, n;
    exp_t e;
    if (k >= 1 && k <= KM)
      for (int i = 0; i < L; i++) begin
        s = 0;
        for (int j = 0; j < k; j++)
          s += int'($signed(a_mem[j][i*EW +: EW])) * int'($signed(b_mem[j][i*EW +: EW]));
        e.data = AW'(s);
        e.last = (i == L - 1);
        q.push_back(e);
      end
    @(posedge clk); #1;
    start = 1'b1;
    cfg_k = 16'(k);
    @(posedge clk); #1;
    start = 1'b0;
    if (k >= 1 && k <= KM) begin
      for (int j = 0; j < k; j++) begin
        s_axis_a_tdata  = a_mem[j];
        s_axis_b_tdata  = b_mem[j];
        s_axis_a_tlast  = a_last_mem[j];
        s_axis_b_tlast  = b_last_mem[j];
        s_axis_a_tvalid = 1'b1;
        if (j == 0) begin
          s_axis_b_tvalid = 1'b0;
          @(negedge clk);
          n_cmp++;
          if (s_axis_a_tready !== 1'b0 || s_axis_b_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL half_valid_ready: a_ready=%b b_ready=%b, required 0 0", s_axis_a_tready, s_axis_b_tready);
          end
          @(posedge clk); #1;
        end
        s_axis_b_tvalid = 1'b1;
        if (start_mid && j == 1) begin
          start = 1'b1;
          cfg_k = 16'd2;
        end
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!s_axis_a_tready && n < 100);
        n_cmp++;
        if (s_axis_a_tready !== 1'b1 || s_axis_b_tready !== 1'b1 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL beat_accept[%0d]: a_ready=%b b_ready=%b busy=%b, required 1 1 1",
                   j, s_axis_a_tready, s_axis_b_tready, busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      s_axis_a_tvalid = 1'b0;
      s_axis_b_tvalid = 1'b0;
      s_axis_a_tlast  = 1'b0;
      s_axis_b_tlast  = 1'b0;
    end
  endtask
  task automatic run_job(input string name, input int k, input bit start_mid, input logic exp_err);
    int c0, p0, n, beats;
    c0 = c_count;
    p0 = n_pulse;
    beats = (k >= 1 && k <= KM) ? L : 0;
    start_job(k, start_mid);
    n = 0;
    while (!(done === 1'b1 && busy === 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n >= 400) begin
      n_bad++;
      $display("FAIL %s done_timeout: done=%b busy=%b, required done=1 busy=0", name, done, busy);
    end
    n_cmp++;
    if (c_count - c0 != beats || q.size() != 0) begin
      n_bad++;
      $display("FAIL %s c_count: got %0d beats (%0d pending), required %0d", name, c_count - c0, q.size(), beats);
    end
    n_cmp++;
    if (n_pulse - p0 != 1) begin
      n_bad++;
      $display("FAIL %s done_pulse: got %0d pulses, required 1", name, n_pulse - p0);
    end
    n_cmp++;
    if (done !== 1'b1 || err !== exp_err || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s flags: done=%b err=%b busy=%b, required done=1 err=%b busy=0", name, done, err, busy, exp_err);
    end
    q.delete();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_axis_a_tready, s_axis_b_tready, m_axis_c_tvalid, m_axis_c_tlast, busy, done, done_pulse, err, irq} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required all zero",
               {s_axis_a_tready, s_axis_b_tready, m_axis_c_tvalid, m_axis_c_tlast, busy, done, done_pulse, err, irq});
    end
    n_cmp++;
    if (m_axis_c_tdata !== '0) begin
      n_bad++;
      $display("FAIL reset_tdata: got %h, required 0", m_axis_c_tdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    irq_en = 1'b0;
    fill_basic();
    run_job("basic", 4, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_sticky: done=%b irq=%b, required done=1 irq=0", done, irq);
    end
  endtask
  task automatic test_stall();
    tr_mode = 1;
    fill_basic();
    run_job("stall", 4, 1'b0, 1'b0);
    fill_rand(5);
    run_job("stall_rand", 5, 1'b0, 1'b0);
    tr_mode = 0;
  endtask
  task automatic test_tlast_err();
    fill_rand(4);
    a_last_mem[1] = 1'b1;
    run_job("tlast_err", 4, 1'b0, 1'b1);
  endtask
  task automatic test_cfg_err();
    run_job("cfg_k0", 0, 1'b0, 1'b1);
    run_job("cfg_k65", 65, 1'b0, 1'b1);
  endtask
  task automatic test_kmax();
    fill_rand(KM);
    run_job("kmax", KM, 1'b0, 1'b0);
  endtask
  task automatic test_irq();
    irq_en = 1'b1;
    fill_rand(3);
    run_job("irq", 3, 1'b1, 1'b0);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_set: irq=%b, required 1", irq);
    end
    @(posedge clk); #1;
    sw_clear_done = 1'b1;
    @(posedge clk); #1;
    sw_clear_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || irq !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_clear: done=%b irq=%b err=%b, required 0 0 0", done, irq, err);
    end
  endtask
  task automatic test_reset_mid();
    int c0, p0;
    tr_mode = 2;
    m_axis_c_tready = 1'b0;
    fill_basic();
    c0 = c_count;
    p0 = n_pulse;
    start_job(4, 1'b0);
    m_axis_c_tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_axis_c_tready = 1'b0;
    n_cmp++;
    if (c_count - c0 != 2) begin
      n_bad++;
      $display("FAIL rst_mid_beats: got %0d beats before reset, required 2", c_count - c0);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s_axis_a_tready, s_axis_b_tready, m_axis_c_tvalid, m_axis_c_tlast, busy, done, done_pulse, err, irq} !== 9'b0 ||
        m_axis_c_tdata !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: ctrl=%b data=%h, required all zero",
               {s_axis_a_tready, s_axis_b_tready, m_axis_c_tvalid, m_axis_c_tlast, busy, done, done_pulse, err, irq},
               m_axis_c_tdata);
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tr_mode = 0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (c_count - c0 != 2 || n_pulse != p0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_abandon: beats=%0d pulses=%0d busy=%b, required 2 0 0", c_count - c0, n_pulse - p0, busy);
    end
    a_mem[0] = {4{8'd2}};
    b_mem[0] = {4{8'd2}};
    a_last_mem[0] = 1'b1;
    b_last_mem[0] = 1'b1;
    run_job("after_rst", 1, 1'b0, 1'b0);
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_pulse = 0;
    c_count = 0;
    tr_mode = 0;
    s_axis_a_tdata = '0;
    s_axis_b_tdata = '0;
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
    s_axis_a_tlast = 1'b0;
    s_axis_b_tlast = 1'b0;
    m_axis_c_tready = 1'b1;
    cfg_k = '0;
    start = 1'b0;
    irq_en = 1'b1;
    sw_clear_done = 1'b0;
    fork
      monitor();
      drive_tready();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_tlast_err();
    test_cfg_err();
    test_kmax();
    test_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
